// File: rtl/uart_rx_sampler.sv
// Oversampling UART receiver driven by an external tick_en strobe; frames are start + DATA_BITS + stop.
// Define UART_RX_SAMPLER_PARITY_EN to add one even-parity bit between the data bits and the stop bit.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_SAMPLER_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                 state, state_next;
    logic [TW-1:0]          tick_cnt, tick_next;
    logic [BW-1:0]          bit_cnt, bit_next;
    logic [DATA_BITS-1:0]   shift, shift_next;
    logic [DATA_BITS-1:0]   data_next;
    logic                   valid_next, ferr_next;
    logic                   rxd_meta, rxd_sync;

    // NOTE: the synchroniser resets to the idle line level so release of reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

`ifdef UART_RX_SAMPLER_PARITY_EN
    logic parity_bad, pbad_next, perr_next;
`endif

    // NOTE: every combinational output is defaulted first, so no path through the case can infer a latch.
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        data_next  = data_out;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_SAMPLER_PARITY_EN
        pbad_next  = parity_bad;
        perr_next  = 1'b0;
`endif
        if (tick_en) begin
            case (state)
                S_IDLE: begin
                    if (!rxd_sync) begin
                        state_next = S_START;
                        tick_next  = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == HALF_LAST) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = rxd_sync ? S_IDLE : S_DATA;
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        shift_next = {rxd_sync, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_next = '0;
`ifdef UART_RX_SAMPLER_PARITY_EN
                            state_next = S_PARITY;
`else
                            state_next = S_STOP;
`endif
                        end else begin
                            bit_next = bit_cnt + BW'(1);
                        end
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
`ifdef UART_RX_SAMPLER_PARITY_EN
                S_PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next  = '0;
                        pbad_next  = rxd_sync ^ (^shift);
                        state_next = S_STOP;
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_next = '0;
                        if (rxd_sync) begin
                            state_next = S_IDLE;
`ifdef UART_RX_SAMPLER_PARITY_EN
                            if (parity_bad) begin
                                perr_next = 1'b1;
                            end else begin
                                data_next  = shift;
                                valid_next = 1'b1;
                            end
`else
                            data_next  = shift;
                            valid_next = 1'b1;
`endif
                        end else begin
                            // A low stop bit may be a break; hold off until the line recovers.
                            state_next = S_WAIT_HIGH;
                            ferr_next  = 1'b1;
`ifdef UART_RX_SAMPLER_PARITY_EN
                            perr_next  = parity_bad;
`endif
                        end
                    end else begin
                        tick_next = tick_cnt + TW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxd_sync) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            tick_cnt   <= tick_next;
            bit_cnt    <= bit_next;
            shift      <= shift_next;
            data_out   <= data_next;
            data_valid <= valid_next;
            frame_err  <= ferr_next;
        end
    end

`ifdef UART_RX_SAMPLER_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_bad <= pbad_next;
            parity_err <= perr_next;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: directed frames push expected pulses, a negedge monitor pops and compares.
module tb_uart_rx_sampler;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef UART_RX_SAMPLER_PARITY_EN
    localparam int FRAME_BITS = DB + 3;
`else
    localparam int FRAME_BITS = DB + 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          tick_en;
    logic          rxd;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    uart_rx_sampler #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .rxd        (rxd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic          ferr;
        logic          perr;
        logic [DB-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   valid_cycles[$];
    int   errors   = 0;
    int   checks   = 0;
    int   cycle    = 0;
    int   tick_div = 4;
`ifdef UART_RX_SAMPLER_PARITY_EN
    logic par_flip = 1'b0;
`endif

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic f, input logic p, input logic [DB-1:0] d);
        exp_t e;
        e.valid = v;
        e.ferr  = f;
        e.perr  = p;
        e.data  = d;
        sb.push_back(e);
    endtask

    // Tick generator: one-clk tick_en every tick_div clocks (tick_div=1 ties it high).
    initial begin
        int c = 0;
        tick_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (c >= tick_div - 1) begin
                c = 0;
                tick_en = 1'b1;
            end else begin
                c++;
                tick_en = 1'b0;
            end
        end
    end

    task automatic hold_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick_en) k++;
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        #1;
        rxd = b;
        hold_ticks(n);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b);
        send_bit(1'b0, OS);
        for (int i = 0; i < DB; i++) send_bit(d[i], OS);
`ifdef UART_RX_SAMPLER_PARITY_EN
        send_bit((^d) ^ par_flip, OS);
`endif
        send_bit(stop_b, OS);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && (data_valid || frame_err || parity_err)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got valid=%b ferr=%b perr=%b, required no pulse",
                             data_valid, frame_err, parity_err);
                end else begin
                    e = sb.pop_front();
                    check("pulse_flags", {data_valid, frame_err, parity_err}, {e.valid, e.ferr, e.perr});
                    check("pulse_data_out", data_out, e.data);
                end
                if (data_valid) valid_cycles.push_back(cycle);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("reset_data_out", data_out, 0);
        check("reset_data_valid", data_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_parity_err", parity_err, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        hold_ticks(4);

        // Good frame, tick every 4 clk.
        push(1'b1, 1'b0, 1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_drain("a5");
        hold_ticks(2);
        #2;
        check("a5_busy_after", busy, 0);
        check("a5_data_out", data_out, 8'hA5);

        // Short low glitch is rejected at the START re-sample.
        send_bit(1'b0, 4);
        #2;
        check("glitch_busy_during", busy, 1);
        send_bit(1'b1, 7);
        #2;
        check("glitch_busy_after", busy, 0);
        check("glitch_data_kept", data_out, 8'hA5);

        // Low stop bit followed by a break.
        push(1'b0, 1'b1, 1'b0, 8'hA5);
        send_frame(8'h3C, 1'b0);
        send_bit(1'b0, 40);
        #2;
        check("break_busy_held", busy, 1);
        check("break_data_kept", data_out, 8'hA5);
        wait_drain("ferr");
        send_bit(1'b1, 3);
        #2;
        check("break_busy_released", busy, 0);
        hold_ticks(4);

        // Reset in the middle of data bit 3 of 0x12.
        send_bit(1'b0, OS);
        send_bit(1'b0, OS);
        send_bit(1'b1, OS);
        send_bit(1'b0, OS);
        send_bit(1'b0, OS / 2);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_data_out", data_out, 0);
        check("midreset_data_valid", data_valid, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_parity_err", parity_err, 0);
        check("midreset_busy", busy, 0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        hold_ticks(4);
        push(1'b1, 1'b0, 1'b0, 8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_drain("after_reset");

        // Back-to-back frames with tick_en tied high.
        tick_div = 1;
        hold_ticks(8);
        valid_cycles.delete();
        push(1'b1, 1'b0, 1'b0, 8'h55);
        push(1'b1, 1'b0, 1'b0, 8'hAA);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        wait_drain("b2b");
        check("b2b_pulse_count", valid_cycles.size(), 2);
        if (valid_cycles.size() == 2)
            check("b2b_pulse_gap", valid_cycles[1] - valid_cycles[0], OS * FRAME_BITS);
        hold_ticks(4);

`ifdef UART_RX_SAMPLER_PARITY_EN
        tick_div = 4;
        hold_ticks(4);
        par_flip = 1'b1;
        push(1'b0, 1'b0, 1'b1, 8'hAA);
        send_frame(8'h07, 1'b1);
        wait_drain("par_bad");
        par_flip = 1'b0;
        push(1'b1, 1'b0, 1'b0, 8'h07);
        send_frame(8'h07, 1'b1);
        wait_drain("par_good");
        hold_ticks(2);
        #2;
        check("par_good_data_out", data_out, 8'h07);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_sampler.md
UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: tick_en pulses per bit; even, 4..64.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; 5..8.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port tick_en, input, 1: one-clk-wide oversample enable from the upstream decimator's clk_dez output.
REQ-006 SHALL have port rxd, input, 1: asynchronous serial line; idle high.
REQ-007 SHALL have port data_out, output, DATA_BITS: last good received word.
REQ-008 SHALL have port data_valid, output, 1: one-clk pulse; data_out updated.
REQ-009 SHALL have port frame_err, output, 1: one-clk pulse; stop bit sampled low.
REQ-010 SHALL have port parity_err, output, 1: one-clk pulse; parity mismatch (see Configuration).
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 SHALL synchronise rxd through two flip-flops; all decisions use the synchronised value (2-clk input latency).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH; tick counter and bit counter advance only on cycles with tick_en=1.
REQ-014 IDLE: on a tick with synchronised rxd=0, SHALL go to START and clear the tick counter.
REQ-015 START: after OVERSAMPLE/2 ticks, SHALL re-sample; rxd=0 -> DATA; rxd=1 -> IDLE (glitch reject, no pulse output).
REQ-016 DATA: SHALL sample every OVERSAMPLE ticks, shift in LSB first; after DATA_BITS samples go to PARITY (macro) or STOP.
REQ-017 STOP: after OVERSAMPLE ticks, SHALL sample; 1 -> load data_out, pulse data_valid, go to IDLE; 0 -> pulse frame_err, keep data_out, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL remain until synchronised rxd=1 on a tick, then go to IDLE (break-condition handling).
REQ-019 data_valid/frame_err/parity_err SHALL assert in the clk cycle following the tick on which the stop bit is sampled; exactly one clk wide regardless of tick_en rate.
REQ-020 With tick_en tied high, SHALL operate at OVERSAMPLE clk per bit.
REQ-021 Frame parity fault and stop fault together SHALL pulse both parity_err and frame_err; data_valid SHALL not pulse.
REQ-022 A new start bit detected in IDLE the tick after STOP SHALL be accepted (back-to-back frames, no idle gap required).

Reset
REQ-023 While reset=1, SHALL force state IDLE, counters 0, synchroniser flops 1, data_out 0, data_valid/frame_err/parity_err/busy 0, independent of clk.
REQ-024 Reset asserted mid-frame SHALL discard the partial word; after release, the next start bit SHALL be received normally.

Configuration
REQ-025 Macro UART_RX_SAMPLER_PARITY_EN defined: PARITY state present; one even-parity bit sampled after the data bits; mismatch -> parity_err pulse, data_out not updated, data_valid not pulsed.
REQ-026 Macro undefined: no PARITY state, frame = start + DATA_BITS + stop; parity_err SHALL be constant 0.

Verification
REQ-027 Defaults, tick_en every 4 clk, send 0xA5 with valid stop -> data_out=0xA5, one data_valid pulse, busy low afterwards.
REQ-028 rxd low for 4 ticks then high -> no output pulses, state back to IDLE, busy low within 1 clk of the START re-sample tick.
REQ-029 Send 0x3C with stop bit 0, then hold rxd low 40 ticks -> frame_err pulse once, data_out keeps previous value, busy stays high until rxd returns high.
REQ-030 Assert reset at data bit 3 of 0x12, release, send 0x3C -> all outputs 0 during reset, then data_out=0x3C with one data_valid pulse.
REQ-031 Back-to-back 0x55 then 0xAA, no idle gap, tick_en tied high -> two data_valid pulses, 160 clk apart, in order.
REQ-032 With UART_RX_SAMPLER_PARITY_EN, send 0x07 with parity bit 0 -> parity_err pulse, no data_valid; send 0x07 with parity bit 1 -> data_valid, data_out=0x07.
